// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB completer with a byte-wide register file and a fixed number of
//   wait states per transfer. Out-of-range local addresses and an access
//   phase that arrives without a setup phase are reported on PSLVERR.
//
// Parameters
//   DEPTH        number of 8-bit locations (legal local addresses 0..DEPTH-1, <=256)
//   WAIT_CYCLES  access cycles with PREADY low before completion (0..15)
//
// Ports
//   PCLK     in   bus clock, rising edge
//   PRESET   in   synchronous active-high reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [8:0] bus address; bit 8 is the bridge's select bit and is ignored
//   PWDATA   in   [7:0] write data
//   PRDATA   out  [7:0] read data (zero unless a good read is completing)
//   PREADY   out  transfer completion
//   PSLVERR  out  error response, qualified by PREADY
module apb_slave_mem #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  logic       setup;
  logic       mem_we;
  logic [7:0] rd_data;
  logic       unused_paddr_msb;

  assign setup            = PSEL & ~PENABLE;
  assign unused_paddr_msb = PADDR[8];

  // State register and all captured transfer fields.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        // PSEL & PENABLE here is a protocol violation: stay put, no write.
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            mem_we  = wr_q & ~err_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A setup phase restarts the transfer from either state, dropping any
    // transfer still waiting in ACCESS.
    if (setup) begin
      state_d = ACCESS;
      addr_d  = PADDR[7:0];
      wr_d    = PWRITE;
      wdata_d = PWDATA;
      err_d   = {1'b0, PADDR[7:0]} >= DEPTH_LIM;
      cnt_d   = WAIT_LOAD;
    end
  end

  // Memory write port; the address compare avoids indexing with a wider
  // address than the array needs when DEPTH < 256.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (mem_we && (addr_q == 8'(i))) begin
        mem_d[i] = wdata_q;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr_q == 8'(i)) begin
        rd_data = mem_q[i];
      end
    end
  end

  // Output logic.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    case (state_q)
      IDLE: begin
        PREADY  = PSEL & PENABLE;
        PSLVERR = PSEL & PENABLE;
      end
      ACCESS: begin
        PREADY  = (cnt_q == '0);
        PSLVERR = (cnt_q == '0) & err_q;
        if ((cnt_q == '0) && !wr_q && !err_q) begin
          PRDATA = rd_data;
        end
      end
      default: ;
    endcase
  end

endmodule
